wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port and shares it between the MEM/WB pipeline register and the multi-cycle mul/div unit.
- The pipeline always has priority. Mul/div results are either written directly into an idle slot or buffered in a small FIFO and drained later.
- A starvation counter raises a stall request so that buffered results cannot wait indefinitely.
- Sits between the MEM/WB register outputs, the mul/div result port and the register file.

Parameters:
- DEPTH, 2, mul/div result FIFO entries; must be a power of 2 and at least 2.
- STARVE_LIMIT, 4, cycles the FIFO head may wait before stall_req is raised; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_mem_data  in  32  load data from the MEM/WB register.
- wb_alu_data  in  32  ALU result from the MEM/WB register.
- wb_wr_reg  in  5  destination register from the MEM/WB register.
- wb_ctrl  in  2  bit1 = RegWrite, bit0 = MemtoReg (1 selects wb_mem_data).
- md_valid  in  1  mul/div result valid.
- md_data  in  32  mul/div result.
- md_wr_reg  in  5  mul/div destination register.
- md_ready  out  1  arbiter accepts the mul/div result this cycle.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req  out  1  registered request to pipeline control to insert a WB bubble.
- fifo_count  out  log2(DEPTH)+1  current FIFO occupancy, for debug.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - FIFO empty, fifo_count=0, starvation counter=0, stall_req=0, md_ready=0.
  - While reset is high, rf_we is forced to 0, rf_waddr=0 and rf_wdata=0.
  - Reset mid-operation discards all FIFO contents, with no write.
- Pipeline write request: pw = wb_ctrl[1]. Data is wb_mem_data when wb_ctrl[0]=1, otherwise wb_alu_data.
- Write-port grant is combinational, evaluated in this order:
  1. pw=1: the pipeline writes (rf_waddr=wb_wr_reg).
  2. Otherwise, FIFO not empty: the FIFO head writes and is popped at the clock edge.
  3. Otherwise, md_valid=1: the mul/div result bypasses straight to the port; it is not stored.
  4. Otherwise: rf_we=0.
- Register 0: any granted write with address 0 drives rf_we=0. The source is still consumed (popped or accepted), so register 0 is never written.
- md_ready = (FIFO not full) OR (FIFO empty AND pw=0). This is combinational, and a full FIFO that is being popped does not count as having space this cycle. A transfer occurs when md_valid and md_ready are both 1.
- Accepted mul/div result that was not bypassed: pushed into the FIFO at the clock edge. A simultaneous push and pop leaves fifo_count unchanged, and the pointers wrap modulo DEPTH.
- Ordering: the FIFO drains strictly in order. No check is made for the same destination register on both sources; the scoreboard upstream guarantees no such conflict.
- Starvation counter:
  - Resets to 0 when the FIFO is empty or the head is popped.
  - Increments each cycle the FIFO is non-empty and the head is not popped.
  - Saturates at STARVE_LIMIT.
- stall_req:
  - Set at the edge where the counter equals STARVE_LIMIT and the head is not popped.
  - Cleared at the edge where the head pops, or by reset.
- Pipeline contract: while stall_req=1, pipeline control loads a bubble (wb_ctrl=0) into MEM/WB at the next edge. The arbiter does not depend on the contract for correctness, only for progress.
- Latency:
  - Bypass write: 0 cycles, the same cycle as md_valid.
  - Buffered entry: written no earlier than 1 cycle after its push.
  - Worst case with the contract honoured: STARVE_LIMIT+2 cycles from reaching the FIFO head.

Test Plan:
- Reset checks: hold reset for 3 cycles with wb_ctrl=2'b10 and md_valid=1 -> rf_we=0, stall_req=0, fifo_count=0 throughout.
- Pipeline load select: wb_ctrl=2'b11, wb_wr_reg=5, wb_mem_data=32'hDEADBEEF, wb_alu_data=1 -> same cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF.
- Bypass and buffer: wb_ctrl=0 with md_valid=1, md_wr_reg=9, md_data=7 -> immediate write of 7 to register 9 with fifo_count=0. Repeat with wb_ctrl=2'b10 -> pipeline write first, fifo_count=1, and the next idle cycle writes 7 to register 9 with fifo_count back to 0.
- Full FIFO: pw=1 every cycle with DEPTH+1 back-to-back md_valid -> md_ready=0 once fifo_count=DEPTH. Release pw -> entries written in push order, and md_ready returns to 1 only after a pop.
- Starvation: one buffered entry with pw=1 held continuously, STARVE_LIMIT=4 -> stall_req rises on the 5th edge after the push. Drive wb_ctrl=0 next cycle -> the entry is written and stall_req falls at that edge.
- Register 0 and mid-op reset: an md result to register 0 -> rf_we=0 and the entry is consumed. Pulse reset with fifo_count=2 -> FIFO empty next cycle and neither entry is ever written.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: MEM/WB, mul/div and register-file write-port signals around the arbiter.
interface wb_port_arbiter_if #(parameter int DEPTH = 2);
  logic [31:0] wb_mem_data;
  logic [31:0] wb_alu_data;
  logic [4:0] wb_wr_reg;
  logic [1:0] wb_ctrl;
  logic md_valid;
  logic [31:0] md_data;
  logic [4:0] md_wr_reg;
  logic md_ready;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic stall_req;
  logic [$clog2(DEPTH):0] fifo_count;
  modport master (
    output wb_mem_data, wb_alu_data, wb_wr_reg, wb_ctrl, md_valid, md_data, md_wr_reg,
    input md_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
  );
  modport slave (
    input wb_mem_data, wb_alu_data, wb_wr_reg, wb_ctrl, md_valid, md_data, md_wr_reg,
    output md_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between MEM/WB (priority) and a
// mul/div unit whose results bypass into idle slots or queue in a FIFO with starvation stall.
module wb_port_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic reset,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [36:0] mem [DEPTH];
  logic [AW-1:0] rdPtr, wrPtr;
  logic [AW:0] count;
  logic [3:0] starve;
  logic stall;
  logic pw, empty, full, pop, bypass, push, grant;
  logic [4:0] gAddr;
  logic [31:0] gData;
  logic [36:0] head;
  assign pw = bus.wb_ctrl[1];
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign head = mem[rdPtr];
  assign pop = !reset && !pw && !empty;
  assign bypass = !reset && !pw && empty && bus.md_valid;
  assign bus.md_ready = !reset && (!full || (empty && !pw));
  assign push = bus.md_valid && bus.md_ready && !bypass;
  assign grant = !reset && (pw || !empty || bus.md_valid);
  assign gAddr = pw ? bus.wb_wr_reg : !empty ? head[36:32] : bus.md_wr_reg;
  assign gData = pw ? (bus.wb_ctrl[0] ? bus.wb_mem_data : bus.wb_alu_data) : !empty ? head[31:0] : bus.md_data;
  // register 0 is hardwired: the source is still consumed but the write is suppressed
  assign bus.rf_we = grant && gAddr != 5'd0;
  assign bus.rf_waddr = grant ? gAddr : 5'd0;
  assign bus.rf_wdata = grant ? gData : 32'd0;
  assign bus.stall_req = stall;
  assign bus.fifo_count = count;
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= {bus.md_wr_reg, bus.md_data};
  always_ff @(posedge clk)
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      starve <= '0;
      stall <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      starve <= (empty || pop) ? 4'd0 : (starve == 4'(STARVE_LIMIT)) ? starve : starve + 4'd1;
      stall <= pop ? 1'b0 : (!empty && starve == 4'(STARVE_LIMIT)) ? 1'b1 : stall;
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus checked cycle by cycle against a queue-based model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();
  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (.clk(clk), .reset(reset), .bus(bus));
  int nChecks = 0;
  int nPass = 0;
  logic [36:0] q [$];
  int waitCnt = 0;
  bit mStall = 0;
  logic obsWe, obsReady, obsStall;
  logic [4:0] obsAddr;
  logic [31:0] obsData, obsCount;
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // one clock: apply inputs, compare outputs with the model, then advance the model at the edge
  task automatic step(input logic rst, input logic [1:0] ctrl, input logic [4:0] wreg,
                      input logic [31:0] mdat, input logic [31:0] adat, input logic mv,
                      input logic [4:0] mreg, input logic [31:0] mdd);
    bit pw, eg, er, popped, byp;
    int n;
    logic [4:0] ea;
    logic [31:0] ed;
    logic [36:0] h;
    reset = rst;
    bus.wb_ctrl = ctrl;
    bus.wb_wr_reg = wreg;
    bus.wb_mem_data = mdat;
    bus.wb_alu_data = adat;
    bus.md_valid = mv;
    bus.md_wr_reg = mreg;
    bus.md_data = mdd;
    #1;
    pw = ctrl[1];
    n = q.size();
    h = (n > 0) ? q[0] : 37'd0;
    eg = 0; ea = 0; ed = 0;
    if (rst) eg = 0;
    else if (pw) begin eg = 1; ea = wreg; ed = ctrl[0] ? mdat : adat; end
    else if (n > 0) begin eg = 1; ea = h[36:32]; ed = h[31:0]; end
    else if (mv) begin eg = 1; ea = mreg; ed = mdd; end
    er = !rst && (n < DEPTH || (n == 0 && !pw));
    obsWe = bus.rf_we; obsAddr = bus.rf_waddr; obsData = bus.rf_wdata;
    obsReady = bus.md_ready; obsStall = bus.stall_req; obsCount = 32'(bus.fifo_count);
    checkVal("rf_we", 32'(obsWe), 32'(eg && ea != 0));
    checkVal("rf_waddr", 32'(obsAddr), 32'(ea));
    checkVal("rf_wdata", obsData, ed);
    checkVal("md_ready", 32'(obsReady), 32'(er));
    checkVal("stall_req", 32'(obsStall), 32'(mStall));
    checkVal("fifo_count", obsCount, 32'(n));
    @(posedge clk);
    if (rst) begin
      q.delete();
      waitCnt = 0;
      mStall = 0;
    end else begin
      popped = !pw && n > 0;
      byp = !pw && n == 0 && mv;
      if (popped) void'(q.pop_front());
      if (mv && er && !byp) q.push_back({mreg, mdd});
      mStall = popped ? 0 : (n > 0 && waitCnt == LIMIT) ? 1 : mStall;
      waitCnt = (n == 0 || popped) ? 0 : (waitCnt < LIMIT ? waitCnt + 1 : waitCnt);
    end
    @(negedge clk);
  endtask
  task automatic idle();
    step(0, 2'b00, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask
  initial begin
    reset = 1;
    bus.wb_ctrl = 0; bus.wb_wr_reg = 0; bus.wb_mem_data = 0; bus.wb_alu_data = 0;
    bus.md_valid = 0; bus.md_wr_reg = 0; bus.md_data = 0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b10, 5'd3, 32'd1, 32'd2, 1, 5'd4, 32'd5);
      checkVal("reset_we", 32'(obsWe), 32'd0);
      checkVal("reset_count", obsCount, 32'd0);
    end
    step(0, 2'b11, 5'd5, 32'hDEADBEEF, 32'd1, 0, 5'd0, 32'd0);
    checkVal("load_data", obsData, 32'hDEADBEEF);
    checkVal("load_addr", 32'(obsAddr), 32'd5);
    step(0, 2'b00, 5'd0, 32'd0, 32'd0, 1, 5'd9, 32'd7);
    checkVal("bypass_data", obsData, 32'd7);
    checkVal("bypass_addr", 32'(obsAddr), 32'd9);
    step(0, 2'b10, 5'd3, 32'd0, 32'd11, 1, 5'd9, 32'd7);
    checkVal("pipe_first", obsData, 32'd11);
    idle();
    checkVal("buffered_count", obsCount, 32'd1);
    checkVal("buffered_data", obsData, 32'd7);
    idle();
    checkVal("drained_count", obsCount, 32'd0);
    for (int i = 0; i <= DEPTH; i++) step(0, 2'b10, 5'd1, 32'd0, 32'd0, 1, 5'(10 + i), 32'(100 + i));
    checkVal("full_ready", 32'(obsReady), 32'd0);
    step(0, 2'b00, 5'd0, 32'd0, 32'd0, 1, 5'd20, 32'd200);
    checkVal("full_pop_ready", 32'(obsReady), 32'd0);
    checkVal("drain_first", obsData, 32'd100);
    idle();
    checkVal("drain_second", obsData, 32'd101);
    idle();
    step(0, 2'b10, 5'd1, 32'd0, 32'd0, 1, 5'd12, 32'd300);
    for (int i = 1; i <= LIMIT + 1; i++) step(0, 2'b10, 5'd1, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    checkVal("stall_before", 32'(obsStall), 32'd0);
    idle();
    checkVal("stall_high", 32'(obsStall), 32'd1);
    checkVal("starved_write", obsData, 32'd300);
    idle();
    checkVal("stall_low", 32'(obsStall), 32'd0);
    step(0, 2'b00, 5'd0, 32'd0, 32'd0, 1, 5'd0, 32'd55);
    checkVal("r0_bypass_we", 32'(obsWe), 32'd0);
    step(0, 2'b10, 5'd2, 32'd0, 32'd0, 1, 5'd0, 32'd56);
    idle();
    checkVal("r0_pop_we", 32'(obsWe), 32'd0);
    idle();
    checkVal("r0_consumed", obsCount, 32'd0);
    step(0, 2'b10, 5'd2, 32'd0, 32'd0, 1, 5'd20, 32'd400);
    step(0, 2'b10, 5'd2, 32'd0, 32'd0, 1, 5'd21, 32'd401);
    step(1, 2'b00, 5'd0, 32'd0, 32'd0, 0, 5'd0, 32'd0);
    checkVal("midrst_count_before", obsCount, 32'd2);
    idle();
    checkVal("midrst_count", obsCount, 32'd0);
    checkVal("midrst_we", 32'(obsWe), 32'd0);
    for (int i = 0; i < 400; i++) begin
      logic [1:0] c;
      logic [4:0] r;
      c = 2'($urandom_range(0, 3));
      if (bus.stall_req && $urandom_range(0, 3) != 0) c = 2'b00;
      r = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step($urandom_range(0, 49) == 0, c, 5'($urandom), $urandom, $urandom, 1'($urandom), r, $urandom);
    end
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
